sample_rom_arbiter: RTL and testbench

- Shares the single sample-ROM read port between two requesters.
  - Port A: sample playback engine, real-time.
  - Port B: CPU-side sample ROM readback and debug path.
- Sits between the protection/sample-playback logic and the SDRAM sample channel.
- Provides round-robin arbitration, a one-entry last-address cache per port, and a ROM-response timeout that returns 8'h00, the end-of-sample marker.

---
 rtl/sample_rom_arbiter.sv | 174 +++++++++++++++++
 tb/tb_sample_rom_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_rom_arbiter.sv
// -----------------------------------------------------------------------------
// sample_rom_arbiter
//
// This module shares the single sample-ROM read port between two requesters:
//   port A - sample playback engine (real-time)
//   port B - CPU-side sample ROM readback / debug path
//
// It uses round-robin arbitration and keeps a one-entry last-address cache per
// port. If the ROM does not answer in time, the access is abandoned and
// returns 8'h00, which is the end-of-sample marker.
//
// Ports:
//   CLK_32M, reset_n       clock (rising edge), asynchronous active-low reset
//   a_req/a_addr           port A request level + byte address (held until ack)
//   a_ack/a_data           port A one-cycle completion pulse + read data
//   b_req/b_addr           port B request level + byte address
//   b_ack/b_data           port B one-cycle completion pulse + read data
//   rom_req/rom_addr       ROM request level + stable address
//   rom_rdy/rom_data       ROM one-cycle response pulse + data
//   timeout_err            sticky flag, set by any ROM timeout
// -----------------------------------------------------------------------------
module sample_rom_arbiter #(
    parameter int ADDR_W  = 18,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK_32M,
    input  logic              reset_n,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    output logic              a_ack,
    output logic [7:0]        a_data,
    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    output logic              b_ack,
    output logic [7:0]        b_data,
    output logic              rom_req,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic              rom_rdy,
    input  logic [7:0]        rom_data,
    output logic              timeout_err
);

    localparam int               CNT_W    = 10;
    // The counter holds the number of ISSUE cycles already completed. The
    // TIMEOUT-th ISSUE cycle is therefore the cycle in which it equals TIMEOUT-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, HIT, ISSUE, RESP} state_t;

    state_t            state_reg;
    logic              g_port_reg;       // 0 = port A, 1 = port B
    logic              last_grant_reg;
    logic [ADDR_W-1:0] g_addr_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [7:0]        resp_data_reg;    // byte to hand back in RESP
    logic [1:0]        cache_valid_reg;
    logic [ADDR_W-1:0] cache_addr_reg [2];
    logic [7:0]        cache_data_reg [2];
    logic [1:0]        ack_reg;
    logic [7:0]        data_reg [2];
    logic              rom_req_reg;
    logic [ADDR_W-1:0] rom_addr_reg;
    logic              timeout_err_reg;

    logic [1:0]        req_vec;
    logic [ADDR_W-1:0] addr_vec [2];
    logic [1:0]        pending;
    logic [1:0]        hit_vec;
    logic              grant_any;
    logic              grant_port;

    assign req_vec     = {b_req, a_req};
    assign addr_vec[0] = a_addr;
    assign addr_vec[1] = b_addr;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_port
            // A port whose ack is pulsing this cycle is not eligible. This stops
            // a requester that drops req on ack from being served twice.
            assign pending[gi] = req_vec[gi] & ~ack_reg[gi];
            assign hit_vec[gi] = cache_valid_reg[gi] &&
                                 (cache_addr_reg[gi] == addr_vec[gi]);
        end
    endgenerate

    always_comb begin
        grant_any = |pending;
        if (&pending) begin
            grant_port = ~last_grant_reg;
        end else begin
            grant_port = pending[1];
        end
    end

    always_ff @(posedge CLK_32M or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            g_port_reg      <= 1'b0;
            last_grant_reg  <= 1'b1;          // B, so A wins the first tie
            g_addr_reg      <= '0;
            cnt_reg         <= '0;
            resp_data_reg   <= 8'h00;
            cache_valid_reg <= 2'b00;
            ack_reg         <= 2'b00;
            rom_req_reg     <= 1'b0;
            rom_addr_reg    <= '0;
            timeout_err_reg <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                cache_addr_reg[i] <= '0;
                cache_data_reg[i] <= 8'h00;
                data_reg[i]       <= 8'h00;
            end
        end else begin
            ack_reg <= 2'b00;
            case (state_reg)
                IDLE: begin
                    if (grant_any) begin
                        g_port_reg     <= grant_port;
                        g_addr_reg     <= addr_vec[grant_port];
                        last_grant_reg <= grant_port;
                        if (hit_vec[grant_port]) begin
                            state_reg <= HIT;
                        end else begin
                            rom_addr_reg <= addr_vec[grant_port];
                            rom_req_reg  <= 1'b1;
                            cnt_reg      <= '0;
                            state_reg    <= ISSUE;
                        end
                    end
                end
                HIT: begin
                    ack_reg[g_port_reg]  <= 1'b1;
                    data_reg[g_port_reg] <= cache_data_reg[g_port_reg];
                    state_reg            <= IDLE;
                end
                ISSUE: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    // rom_rdy is tested first so a response in the final
                    // cycle still counts as a success.
                    if (rom_rdy) begin
                        resp_data_reg               <= rom_data;
                        cache_data_reg[g_port_reg]  <= rom_data;
                        cache_addr_reg[g_port_reg]  <= g_addr_reg;
                        cache_valid_reg[g_port_reg] <= 1'b1;
                        rom_req_reg                 <= 1'b0;
                        state_reg                   <= RESP;
                    end else if (cnt_reg == CNT_LAST) begin
                        resp_data_reg               <= 8'h00;
                        cache_valid_reg[g_port_reg] <= 1'b0;
                        rom_req_reg                 <= 1'b0;
                        timeout_err_reg             <= 1'b1;
                        state_reg                   <= RESP;
                    end
                end
                RESP: begin
                    ack_reg[g_port_reg]  <= 1'b1;
                    data_reg[g_port_reg] <= resp_data_reg;
                    cnt_reg              <= '0;
                    state_reg            <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign a_ack       = ack_reg[0];
    assign b_ack       = ack_reg[1];
    assign a_data      = data_reg[0];
    assign b_data      = data_reg[1];
    assign rom_req     = rom_req_reg;
    assign rom_addr    = rom_addr_reg;
    assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_sample_rom_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sample_rom_arbiter
// Directed bench with a scoreboard. The stimulus pushes the expected
// {port, data} for each access. A monitor pops one entry per ack and compares
// it. A ROM model answers with data = addr[7:0] + 8'h26 after a programmable
// number of cycles, or never answers. In this bench TIMEOUT = 16.
// -----------------------------------------------------------------------------
module tb_sample_rom_arbiter;

    localparam int ADDR_W = 18;

    logic              clk;
    logic              reset_n;
    logic              a_req;
    logic [ADDR_W-1:0] a_addr;
    logic              a_ack;
    logic [7:0]        a_data;
    logic              b_req;
    logic [ADDR_W-1:0] b_addr;
    logic              b_ack;
    logic [7:0]        b_data;
    logic              rom_req;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_rdy;
    logic [7:0]        rom_data;
    logic              timeout_err;

    sample_rom_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(16)) dut (
        .CLK_32M     (clk),
        .reset_n     (reset_n),
        .a_req       (a_req),
        .a_addr      (a_addr),
        .a_ack       (a_ack),
        .a_data      (a_data),
        .b_req       (b_req),
        .b_addr      (b_addr),
        .b_ack       (b_ack),
        .b_data      (b_data),
        .rom_req     (rom_req),
        .rom_addr    (rom_addr),
        .rom_rdy     (rom_rdy),
        .rom_data    (rom_data),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       port;
        logic [7:0] data;
    } exp_t;
    exp_t exp_q[$];

    // ROM model controls and observations
    bit                rom_en    = 1'b1;
    int                rom_delay = 3;
    int                stray_req = 0;
    int                stray_seen = 0;
    int                hi_cnt = 0;
    int                rom_rises = 0;
    int                last_len = 0;
    logic [ADDR_W-1:0] cap_addr = '0;
    logic [ADDR_W-1:0] last_addr = '0;
    bit                unstable = 1'b0;
    int                ack_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_ack(input logic port, input logic [7:0] data);
        exp_t e;
        ack_count++;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_ack: got ack on port %0d data %0h expected no ack", port, data);
        end else begin
            e = exp_q.pop_front();
            chk("ack_port", {31'd0, port}, {31'd0, e.port});
            chk("ack_data", {24'd0, data}, {24'd0, e.data});
        end
    endtask

    // Monitor: samples acks on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (a_ack) check_ack(1'b0, a_data);
            if (b_ack) check_ack(1'b1, b_data);
        end
    end

    // ROM model
    initial begin
        rom_rdy  = 1'b0;
        rom_data = 8'h00;
        forever begin
            @(negedge clk);
            rom_rdy = 1'b0;
            if (rom_req) begin
                hi_cnt++;
                if (hi_cnt == 1) begin
                    cap_addr = rom_addr;
                    unstable = 1'b0;
                    rom_rises++;
                end else if (rom_addr !== cap_addr) begin
                    unstable = 1'b1;
                end
                if (rom_en && hi_cnt == rom_delay) begin
                    rom_rdy  = 1'b1;
                    rom_data = rom_addr[7:0] + 8'h26;
                end
            end else begin
                if (hi_cnt != 0) begin
                    last_len  = hi_cnt;
                    last_addr = cap_addr;
                    chk("rom_addr_stable", {31'd0, unstable}, 32'd0);
                    hi_cnt = 0;
                end
                if (stray_req != stray_seen) begin
                    stray_seen = stray_req;
                    rom_rdy    = 1'b1;
                    rom_data   = 8'hEE;
                end
            end
        end
    end

    // One access: request, wait for ack (bounded), drop request on ack.
    // Latency is counted in clock edges from raising req to seeing ack.
    task automatic access(input logic port, input logic [ADDR_W-1:0] addr,
                          input logic [7:0] exp, output int lat);
        int  start;
        bit  got;
        exp_t e;
        got = 1'b0;
        e.port = port;
        e.data = exp;
        @(negedge clk);
        exp_q.push_back(e);
        if (port) begin b_req = 1'b1; b_addr = addr; end
        else      begin a_req = 1'b1; a_addr = addr; end
        start = cyc;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if ((port && b_ack) || (!port && a_ack)) got = 1'b1;
        end
        lat = cyc - start;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL ack_wait: got no ack on port %0d required ack within 200 cycles", port);
        end
        if (port) b_req = 1'b0;
        else      a_req = 1'b0;
        $display("txn port=%0d addr=%05h exp=%02h lat=%0d", port, addr, exp, lat);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish required finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        int   rises0;
        int   acks0;
        exp_t e;

        reset_n = 1'b0;
        a_req = 1'b0; a_addr = '0;
        b_req = 1'b0; b_addr = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_a_ack",       {31'd0, a_ack},       32'd0);
        chk("rst_b_ack",       {31'd0, b_ack},       32'd0);
        chk("rst_rom_req",     {31'd0, rom_req},     32'd0);
        chk("rst_rom_addr",    {14'd0, rom_addr},    32'd0);
        chk("rst_a_data",      {24'd0, a_data},      32'd0);
        chk("rst_b_data",      {24'd0, b_data},      32'd0);
        chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
        reset_n = 1'b1;

        // Contention out of reset: both held for 4 transactions -> A,B,A,B.
        // A 0x00110 -> 0x36, B 0x00220 -> 0x46; second round hits the caches.
        rom_en = 1'b1; rom_delay = 3;
        rises0 = rom_rises;
        acks0  = ack_count;
        @(negedge clk);
        e.port = 1'b0; e.data = 8'h36; exp_q.push_back(e);
        e.port = 1'b1; e.data = 8'h46; exp_q.push_back(e);
        e.port = 1'b0; e.data = 8'h36; exp_q.push_back(e);
        e.port = 1'b1; e.data = 8'h46; exp_q.push_back(e);
        a_req = 1'b1; a_addr = 18'h00110;
        b_req = 1'b1; b_addr = 18'h00220;
        for (int i = 0; i < 300 && (ack_count - acks0) < 4; i++) @(negedge clk);
        a_req = 1'b0; b_req = 1'b0;
        $display("txn contention acks=%0d rom_reqs=%0d", ack_count - acks0, rom_rises - rises0);
        chk("cont_acks",     ack_count - acks0, 32'd4);
        chk("cont_rom_reqs", rom_rises - rises0, 32'd2);

        // A only miss: 0x01234 -> 0x5A, rom_rdy 5 cycles after rom_req
        rom_delay = 5;
        rises0 = rom_rises;
        access(1'b0, 18'h01234, 8'h5A, lat);
        chk("missA_rom_reqs", rom_rises - rises0, 32'd1);
        chk("missA_rom_addr", {14'd0, last_addr}, 32'h01234);
        chk("missA_rom_len",  last_len, 32'd5);
        chk("missA_latency",  lat, 32'd7);
        chk("missA_rom_req_low", {31'd0, rom_req}, 32'd0);

        // Cache hit on the same address: no ROM access, latency 2
        rises0 = rom_rises;
        access(1'b0, 18'h01234, 8'h5A, lat);
        chk("hitA_rom_reqs", rom_rises - rises0, 32'd0);
        chk("hitA_latency",  lat, 32'd2);

        // Neighbouring address misses: 0x01235 -> 0x5B
        rises0 = rom_rises;
        access(1'b0, 18'h01235, 8'h5B, lat);
        chk("miss2_rom_reqs", rom_rises - rises0, 32'd1);
        chk("miss2_latency",  lat, 32'd7);

        // rom_rdy on the 16th (timeout) cycle wins: B 0x00340 -> 0x66
        rom_delay = 16;
        access(1'b1, 18'h00340, 8'h66, lat);
        chk("late_latency",     lat, 32'd18);
        chk("late_rom_len",     last_len, 32'd16);
        chk("late_timeout_err", {31'd0, timeout_err}, 32'd0);

        // Timeout: ROM never answers, B 0x00300 -> 0x00
        rom_en = 1'b0;
        access(1'b1, 18'h00300, 8'h00, lat);
        chk("to_rom_len",     last_len, 32'd16);
        chk("to_latency",     lat, 32'd18);
        chk("to_timeout_err", {31'd0, timeout_err}, 32'd1);

        // A rom_rdy while idle is ignored
        @(negedge clk);
        stray_req++;
        repeat (4) @(negedge clk);
        chk("stray_rom_req", {31'd0, rom_req}, 32'd0);
        chk("stray_b_data",  {24'd0, b_data},  32'd0);

        // The timed-out address is not cached: it misses again (0x26)
        rom_en = 1'b1; rom_delay = 2;
        rises0 = rom_rises;
        access(1'b1, 18'h00300, 8'h26, lat);
        chk("retry_rom_reqs", rom_rises - rises0, 32'd1);
        chk("retry_latency",  lat, 32'd4);

        // Cache A 0x00500 (-> 0x26), then reset in the middle of a later miss
        access(1'b0, 18'h00500, 8'h26, lat);
        rom_en = 1'b0;
        @(negedge clk);
        a_req = 1'b1; a_addr = 18'h00600;
        repeat (6) @(negedge clk);
        chk("mid_rom_req_high", {31'd0, rom_req}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rom_req", {31'd0, rom_req}, 32'd0);
        chk("async_a_ack",   {31'd0, a_ack},   32'd0);
        a_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_clears_timeout_err", {31'd0, timeout_err}, 32'd0);
        reset_n = 1'b1;
        $display("txn reset during ISSUE");

        // After reset the previously cached address misses
        rom_en = 1'b1; rom_delay = 3;
        rises0 = rom_rises;
        access(1'b0, 18'h00500, 8'h26, lat);
        chk("post_rst_rom_reqs", rom_rises - rises0, 32'd1);
        chk("post_rst_latency",  lat, 32'd5);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
